// File: rtl/data_sram_resp.sv
// ---------------------------------------------------------------------------
// data_sram_resp
//
// Purpose
//   Responder for the CPU data-side SRAM port. It performs byte-enabled stores
//   into word-addressed storage and returns load data one cycle after the
//   request. Requests that are out of range or that use an unsupported
//   byte-enable pattern are dropped, and they set a sticky error flag.
//   Saturating counters record the accepted loads and stores for debug.
//
// Optional feature (macro DSRAM_MMIO_EN)
//   When the macro is defined, physical addresses 0x1FAF_0000..0x1FAF_FFFF go
//   to MMIO instead of RAM:
//     0x1FAF_F000  LED register. 32-bit read/write, byte-enable writes.
//     0x1FAF_E000  TIMER. It increments every clock. A store with wen=1111
//                  loads it; other legal wen values do not change it. A load
//                  returns the value the timer held just before the sampling
//                  edge, so a load issued N cycles after a TIMER store
//                  returns (stored value + N - 1).
//     Any other offset in the window is a bad request.
//   When the macro is undefined, the window gets plain range checking.
//
// Ports
//   clk              in   1      clock; every state update is on posedge
//   rst              in   1      synchronous, active-high reset
//   data_sram_en     in   1      request valid this cycle
//   data_sram_wen    in   4      byte write enables; 4'b0000 = load
//   data_sram_addr   in   32     byte address; bits [31:29] are ignored
//   data_sram_wdata  in   32     store data; byte lanes line up with wen
//   data_sram_rdata  out  32     load data, valid the cycle after a load
//   addr_err         out  1      sticky: a bad request occurred since reset
//   rd_cnt           out  CNT_W  accepted loads, saturating
//   wr_cnt           out  CNT_W  accepted stores, saturating
// ---------------------------------------------------------------------------
module data_sram_resp #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_wen,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic             addr_err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [31:0]       r_rdata;
    logic              r_addr_err;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;

    logic [31:0]       w_pa;
    logic [ADDR_W-1:0] w_wi;
    logic              w_ram_range;
    logic              w_legal_wen;
    logic              w_is_load;
    logic              w_addr_ok;
    logic              w_good;
    logic              w_bad;
    logic              w_do_load;
    logic              w_do_store;
    logic              w_ram_wr;
    logic              w_win;
    logic              w_led_hit;
    logic              w_tmr_hit;
    logic [31:0]       w_mmio_rdata;
    logic              w_unused;

    // Address decode: the virtual segment bits are dropped to form the
    // physical address.
    assign w_pa        = {3'b000, data_sram_addr[28:0]};
    assign w_wi        = w_pa[ADDR_W+1:2];
    assign w_ram_range = (w_pa[31:ADDR_W+2] == '0);
    assign w_is_load   = (data_sram_wen == 4'b0000);

    // The byte-lane bits never select anything because storage is word
    // addressed.
    assign w_unused = &{1'b0, w_pa[1:0]};

    // Only naturally aligned byte, halfword and word patterns are supported.
    always_comb begin
        w_legal_wen = 1'b0;
        case (data_sram_wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_legal_wen = 1'b1;
            default:                   w_legal_wen = 1'b0;
        endcase
    end

`ifdef DSRAM_MMIO_EN
    logic [31:0] r_led;
    logic [31:0] r_timer;

    // The window covers pa[28:16] == 0x1FAF. Registers are decoded on the
    // word index within the 64 KiB window.
    assign w_win     = (w_pa[28:16] == 13'h1FAF);
    assign w_led_hit = w_win && (w_pa[15:2] == 14'h3C00);  // 0xF000
    assign w_tmr_hit = w_win && (w_pa[15:2] == 14'h3800);  // 0xE000

    assign w_mmio_rdata = w_led_hit ? r_led   :
                          w_tmr_hit ? r_timer : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led   <= 32'h0;
            r_timer <= 32'h0;
        end else begin
            if (w_do_store && w_led_hit) begin
                for (int k = 0; k < 4; k++) begin
                    if (data_sram_wen[k]) begin
                        r_led[8*k +: 8] <= data_sram_wdata[8*k +: 8];
                    end
                end
            end
            // A full-word store overrides the free-running increment.
            if (w_do_store && w_tmr_hit && (data_sram_wen == 4'b1111)) begin
                r_timer <= data_sram_wdata;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end
`else
    assign w_win        = 1'b0;
    assign w_led_hit    = 1'b0;
    assign w_tmr_hit    = 1'b0;
    assign w_mmio_rdata = 32'h0;
`endif

    // Inside the MMIO window only the decoded registers are legal targets.
    // Outside it, the RAM range check applies.
    assign w_addr_ok  = w_win ? (w_led_hit | w_tmr_hit) : w_ram_range;
    assign w_good     = data_sram_en && w_legal_wen && w_addr_ok;
    assign w_bad      = data_sram_en && !w_good;
    assign w_do_load  = w_good && w_is_load;
    assign w_do_store = w_good && !w_is_load;
    // Reset has priority over a request in the same cycle, so the write
    // is dropped.
    assign w_ram_wr   = w_do_store && !w_win && !rst;

    // NOTE: the storage array is deliberately left out of reset. RAM macros
    // have no reset port, and the array is meant to keep its contents
    // across rst.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (data_sram_wen[k]) begin
                    r_mem[w_wi][8*k +: 8] <= data_sram_wdata[8*k +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. A read of
    // r_mem here sees the value from before this edge, and a store from
    // the previous cycle has already landed, so a load in the cycle after
    // a store returns the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= 32'h0;
            r_addr_err <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            if (w_bad) begin
                r_addr_err <= 1'b1;
                if (w_is_load) begin
                    r_rdata <= 32'h0;
                end
            end
            if (w_do_load) begin
                r_rdata <= w_win ? w_mmio_rdata : r_mem[w_wi];
                if (r_rd_cnt != CNT_MAX) begin
                    r_rd_cnt <= r_rd_cnt + CNT_ONE;
                end
            end
            if (w_do_store && (r_wr_cnt != CNT_MAX)) begin
                r_wr_cnt <= r_wr_cnt + CNT_ONE;
            end
        end
    end

    assign data_sram_rdata = r_rdata;
    assign addr_err        = r_addr_err;
    assign rd_cnt          = r_rd_cnt;
    assign wr_cnt          = r_wr_cnt;

endmodule

// File: tb/tb_data_sram_resp.sv
// ---------------------------------------------------------------------------
// tb_data_sram_resp
//
// Directed bench for data_sram_resp. Inputs change on the falling edge, and
// outputs are sampled on the next falling edge, which comes after the posedge
// that consumed the request. Expected values are worked out by hand.
//
// A second instance with CNT_W=2 receives the same stimulus and is used to
// check that the counters saturate. The MMIO section is guarded by
// DSRAM_MMIO_EN in the same way as the RAM design.
// ---------------------------------------------------------------------------
module tb_data_sram_resp;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata;
    logic        aerr;
    logic [31:0] rdc;
    logic [31:0] wrc;

    logic [31:0] s_rdata;
    logic        s_aerr;
    logic [1:0]  s_rdc;
    logic [1:0]  s_wrc;

    int n_cmp;
    int n_err;

    data_sram_resp #(.ADDR_W(10), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .addr_err        (aerr),
        .rd_cnt          (rdc),
        .wr_cnt          (wrc)
    );

    data_sram_resp #(.ADDR_W(10), .CNT_W(2)) dut_sat (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (s_rdata),
        .addr_err        (s_aerr),
        .rd_cnt          (s_rdc),
        .wr_cnt          (s_wrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Presents one request; returns after the posedge that consumes it.
    task automatic req(input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d);
        req(1'b1, w, a, d);
    endtask

    task automatic load(input logic [31:0] a);
        req(1'b1, 4'b0000, a, 32'h0);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        en    = 1'b0;
        wen   = 4'b0000;
        addr  = 32'h0;
        wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_rdata", rdata, 32'h0);
        check("rst_aerr",  aerr,  1'b0);
        check("rst_rdcnt", rdc,   32'd0);
        check("rst_wrcnt", wrc,   32'd0);

        // 1: full-word store, then load through a kseg-style address
        store(32'h8000_0010, 4'b1111, 32'hDEAD_BEEF);
        load(32'h8000_0010);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_wrcnt", wrc, 32'd1);
        check("t1_rdcnt", rdc, 32'd1);
        check("t1_sat_wr", s_wrc, 2'd1);

        // 2: partial byte-enable merges
        store(32'h20, 4'b1111, 32'h1122_3344);
        store(32'h20, 4'b0010, 32'h0000_AA00);
        load(32'h20);
        check("t2_wen0010", rdata, 32'h1122_AA44);
        store(32'h20, 4'b1100, 32'hBBCC_0000);
        load(32'h20);
        check("t2_wen1100", rdata, 32'hBBCC_AA44);
        store(32'h24, 4'b1111, 32'h0000_0000);
        store(32'h24, 4'b0001, 32'h9999_9912);
        store(32'h24, 4'b1000, 32'h3477_7777);
        load(32'h24);
        check("t2_wen0001_1000", rdata, 32'h3400_0012);
        store(32'h24, 4'b0100, 32'h0056_0000);
        store(32'h24, 4'b0011, 32'h0000_ABCD);
        load(32'h24);
        check("t2_wen0100_0011", rdata, 32'h3456_ABCD);
        check("t2_wrcnt", wrc, 32'd9);
        check("t2_rdcnt", rdc, 32'd5);
        check("t2_sat_wr", s_wrc, 2'd3);
        check("t2_sat_rd", s_rdc, 2'd3);
        check("t2_aerr_clean", aerr, 1'b0);

        // 3: illegal wen is dropped, and the error flag is sticky until rst
        store(32'h30, 4'b1111, 32'hCAFE_F00D);
        store(32'h30, 4'b0101, 32'hFFFF_FFFF);
        check("t3_aerr", aerr, 1'b1);
        check("t3_wrcnt", wrc, 32'd10);
        load(32'h30);
        check("t3_mem_kept", rdata, 32'hCAFE_F00D);
        idle(10);
        check("t3_aerr_sticky", aerr, 1'b1);
        check("t3_rdata_hold", rdata, 32'hCAFE_F00D);
        pulse_rst();
        check("t3_rst_aerr", aerr, 1'b0);
        check("t3_rst_rdata", rdata, 32'h0);
        check("t3_rst_wrcnt", wrc, 32'd0);
        check("t3_rst_sat_rd", s_rdc, 2'd0);
        load(32'h30);
        check("t3_mem_survives_rst", rdata, 32'hCAFE_F00D);
        check("t3_rdcnt", rdc, 32'd1);

        // 4: out-of-range load, then range boundary and aliasing
        store(32'h0, 4'b1111, 32'h0BAD_C0DE);
        load(32'h0000_1000);
        check("t4_oor_rdata", rdata, 32'h0);
        check("t4_oor_aerr", aerr, 1'b1);
        check("t4_oor_rdcnt", rdc, 32'd1);
        load(32'h0);
        check("t4_no_stall", rdata, 32'h0BAD_C0DE);
        store(32'h0000_0FFC, 4'b1111, 32'hFEED_FACE);
        load(32'hE000_0FFC);
        check("t4_top_word", rdata, 32'hFEED_FACE);
        store(32'h0000_1FFC, 4'b1111, 32'h0000_0000);
        load(32'h0000_0FFC);
        check("t4_no_alias_write", rdata, 32'hFEED_FACE);
        check("t4_wrcnt", wrc, 32'd2);
        check("t4_rdcnt", rdc, 32'd4);

        // 5: back-to-back store/load, then rst asserted together with a store
        store(32'h44, 4'b1111, 32'h1234_5678);
        store(32'h40, 4'b1111, 32'h0000_0055);
        load(32'h40);
        check("t5_b2b", rdata, 32'h0000_0055);
        rst = 1'b1;
        store(32'h44, 4'b1111, 32'h0000_0077);
        rst = 1'b0;
        check("t5_rst_rdcnt", rdc, 32'd0);
        check("t5_rst_wrcnt", wrc, 32'd0);
        check("t5_rst_rdata", rdata, 32'h0);
        load(32'h44);
        check("t5_write_dropped", rdata, 32'h1234_5678);
        check("t5_rdcnt", rdc, 32'd1);

`ifdef DSRAM_MMIO_EN
        // 6: LED register and TIMER
        store(32'hBFAF_F000, 4'b1111, 32'h0000_00FF);
        load(32'hBFAF_F000);
        check("t6_led", rdata, 32'h0000_00FF);
        store(32'hBFAF_F000, 4'b0010, 32'h0000_AB00);
        load(32'hBFAF_F000);
        check("t6_led_byte", rdata, 32'h0000_ABFF);
        store(32'hBFAF_E000, 4'b1111, 32'd100);
        idle(4);
        load(32'hBFAF_E000);
        check("t6_timer", rdata, 32'd104);
        check("t6_aerr_clean", aerr, 1'b0);
        check("t6_wrcnt", wrc, 32'd3);
        check("t6_rdcnt", rdc, 32'd4);
        load(32'hBFAF_0000);
        check("t6_bad_off_rdata", rdata, 32'h0);
        check("t6_bad_off_aerr", aerr, 1'b1);
`else
        // 6: without MMIO, the window is simply out of range
        load(32'hBFAF_F000);
        check("t6_win_rdata", rdata, 32'h0);
        check("t6_win_aerr", aerr, 1'b1);
        check("t6_win_rdcnt", rdc, 32'd1);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
